data_mem_responder: RTL and testbench

- Responder end of the CPU data-memory port. Sampled every cycle: address, write data, write enable. Returns registered read data.
- Backing store: byte-wide RAM holding vector/scalar elements. Only the low 8 bits of write data are stored.
- Memory-mapped region for the 11 board buttons: synchronised, rising-edge sticky, read-to-clear.
- Status word counting RAM writes.
- Sits outside the CPU, beside the instruction ROM; the CPU's MEM stage is the only initiator.

---
 rtl/data_mem_responder.sv | 135 +++++++++++++
 tb/tb_data_mem_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the CPU data-memory port. Every clock edge is one
//   transaction: the address/write-enable/write-data presented before the edge
//   are acted on at the edge and the response appears on rdata_o right after
//   it (fixed one-cycle latency, no handshake).
//
//   Memory map:
//     0 .. DEPTH-1               byte RAM (only wdata_i[7:0] is stored)
//     BTN_BASE .. BTN_BASE+NB-1  button registers {level, sticky-rise}
//     STATUS_ADDR                saturating count of performed RAM writes
//     anything else              unmapped: sets the sticky err_o flag
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-low reset
//   addr_i     byte address from the CPU MEM stage
//   wdata_i    write data, [7:0] used (bit 0 is the W1C bit for buttons)
//   we_i       1 = write, 0 = read
//   buttons_i  raw asynchronous button levels
//   rdata_o    registered read data
//   err_o      sticky unmapped-access flag
module data_mem_responder #(
  parameter int          DEPTH       = 1024,
  parameter int          NB          = 11,
  parameter logic [31:0] BTN_BASE    = 32'h0001_0000,
  parameter logic [31:0] STATUS_ADDR = 32'h0001_0020
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   wdata_i,
  input  logic          we_i,
  input  logic [NB-1:0] buttons_i,
  output logic [31:0]   rdata_o,
  output logic          err_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    ram_q [DEPTH];

  logic [NB-1:0] sync1_q, sync2_q, prev_q, sticky_q, sticky_d;
  logic [NB-1:0] rise;
  logic [NB-1:0] btn_hit;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          is_ram, is_btn, is_stat, is_unmapped;
  logic          ram_wr;
  logic [1:0]    btn_rd;

  // Upper write-data bits are architecturally ignored.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i[31:8];

  // ---------------------------------------------------------------- decode
  assign is_ram      = (addr_i < 32'(DEPTH));
  assign is_stat     = (addr_i == STATUS_ADDR);
  assign is_btn      = |btn_hit;
  assign is_unmapped = ~(is_ram | is_btn | is_stat);
  assign ram_wr      = is_ram & we_i;

  // ------------------------------------------------------- button per-bit
  // Sticky next state: cleared by a read, or by a write with wdata_i[0]=1,
  // of this button's address; a rising edge on the same edge always wins.
  for (genvar gi = 0; gi < NB; gi++) begin : g_btn
    assign btn_hit[gi]  = (addr_i == BTN_BASE + 32'(gi));
    assign rise[gi]     = sync2_q[gi] & ~prev_q[gi];
    assign sticky_d[gi] = rise[gi] |
                          (sticky_q[gi] & ~(btn_hit[gi] & (~we_i | wdata_i[0])));
  end

  // Pre-edge {level, sticky} of the addressed button.
  always_comb begin
    btn_rd = 2'b00;
    for (int i = 0; i < NB; i++) begin
      if (btn_hit[i]) btn_rd = {sync2_q[i], sticky_q[i]};
    end
  end

  // ------------------------------------------------------ next-state logic
  always_comb begin
    cnt_d = cnt_q;
    if (ram_wr && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_comb begin
    rdata_d = 32'h0;
    if (is_ram) begin
      // Write-first: a write returns the byte being written.
      rdata_d = we_i ? {24'h0, wdata_i[7:0]} : {24'h0, ram_q[addr_i[AW-1:0]]};
    end else if (is_btn && !we_i) begin
      rdata_d = {30'h0, btn_rd};
    end else if (is_stat && !we_i) begin
      rdata_d = cnt_q;
    end
  end

  assign err_d = err_q | is_unmapped;

  // --------------------------------------------------------------- storage
  // RAM contents survive reset; the reset term only suppresses a write whose
  // edge is seen while RST is low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
    end else if (ram_wr) begin
      ram_q[addr_i[AW-1:0]] <= wdata_i[7:0];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      sticky_q <= '0;
      cnt_q    <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= buttons_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: the driver pushes the expected
// post-edge response of each transaction; the monitor pops one entry after
// every rising clock edge (and on an asynchronous reset assertion) and
// compares it with the DUT outputs.
module tb_data_mem_responder;

  localparam int          DEPTH = 1024;
  localparam int          NB    = 11;
  localparam logic [31:0] BB    = 32'h0001_0000;
  localparam logic [31:0] STAT  = 32'h0001_0020;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [31:0]   addr_i = 32'h0;
  logic [31:0]   wdata_i = 32'h0;
  logic          we_i = 1'b0;
  logic [NB-1:0] buttons_i = '0;
  logic [31:0]   rdata_o;
  logic          err_o;

  always #5 CLK = ~CLK;

  data_mem_responder #(
    .DEPTH(DEPTH), .NB(NB), .BTN_BASE(BB), .STATUS_ADDR(STAT)
  ) dut (
    .CLK(CLK), .RST(RST), .addr_i(addr_i), .wdata_i(wdata_i), .we_i(we_i),
    .buttons_i(buttons_i), .rdata_o(rdata_o), .err_o(err_o)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_err = 1'b0;

  // Monitor: one scoreboard entry per rising edge or reset assertion.
  always begin : mon
    exp_t e;
    @(posedge CLK or negedge RST);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (rdata_o !== e.rdata) begin
        n_errors++;
        $display("FAIL %s: rdata_o=%h expected %h", e.nm, rdata_o, e.rdata);
      end
      n_checks++;
      if (err_o !== e.err) begin
        n_errors++;
        $display("FAIL %s: err_o=%b expected %b", e.nm, err_o, e.err);
      end
      $display("txn %-22s rdata_o=%h err_o=%b", e.nm, rdata_o, err_o);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic push_exp(input logic [31:0] er, input logic ee, input string nm);
    exp_t e;
    e.rdata = er;
    e.err   = ee;
    e.nm    = nm;
    sb.push_back(e);
  endtask

  // Called at a falling edge: drive one transaction, record its expected
  // response, return at the next falling edge.
  task automatic xact(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [31:0] er, input string nm);
    addr_i  = a;
    we_i    = w;
    wdata_i = d;
    push_exp(er, exp_err, nm);
    @(negedge CLK);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] er, input string nm);
    xact(a, 1'b0, 32'h0, er, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] er, input string nm);
    xact(a, 1'b1, d, er, nm);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) rd(32'd5, 32'hA5, "idle_rd5");
  endtask

  initial begin : stim
    repeat (2) @(negedge CLK);
    push_exp(32'h0, 1'b0, "reset_state");
    @(negedge CLK);
    RST = 1'b1;

    // RAM write-first and read-back, write counter
    wr(32'd5, 32'hA5, 32'hA5, "wr5_write_first");
    rd(32'd5, 32'hA5, "rd5");
    rd(STAT, 32'd1, "cnt_after_1_write");

    // RAM boundaries and upper-bit drop
    wr(32'd0, 32'h3C, 32'h3C, "wr0");
    wr(32'd1023, 32'hC3, 32'hC3, "wr_top");
    wr(32'd1, 32'hFFFF_FF11, 32'h11, "wr1_upper_dropped");
    rd(32'd0, 32'h3C, "rd0");
    rd(32'd1023, 32'hC3, "rd_top");
    rd(32'd1, 32'h11, "rd1");
    rd(STAT, 32'd4, "cnt_after_4_writes");

    // Button 3: 4-cycle pulse, then read-to-clear
    buttons_i[3] = 1'b1;
    idle(4);
    buttons_i[3] = 1'b0;
    idle(2);
    rd(BB + 32'd3, 32'h1, "btn3_sticky_level0");
    rd(BB + 32'd3, 32'h0, "btn3_cleared");

    // Button 7: exact sync latency and set-wins over read-to-clear
    buttons_i[7] = 1'b1;
    rd(BB + 32'd7, 32'h0, "btn7_edge1");
    rd(BB + 32'd7, 32'h0, "btn7_edge2");
    rd(BB + 32'd7, 32'h2, "btn7_rise_edge");
    rd(BB + 32'd7, 32'h3, "btn7_set_won");
    rd(BB + 32'd7, 32'h2, "btn7_cleared");

    // Buttons 9/10: write-1-to-clear vs write-0
    buttons_i[9]  = 1'b1;
    buttons_i[10] = 1'b1;
    idle(3);
    wr(BB + 32'd9, 32'h1, 32'h0, "btn9_w1c");
    wr(BB + 32'd10, 32'h0, 32'h0, "btn10_w0");
    rd(BB + 32'd9, 32'h2, "btn9_after_w1c");
    rd(BB + 32'd10, 32'h3, "btn10_kept");

    // Status write ignored
    wr(STAT, 32'h7, 32'h0, "stat_wr");
    rd(STAT, 32'd4, "cnt_after_stat_wr");

    // Unmapped accesses
    exp_err = 1'b1;
    wr(32'h0000_8000, 32'h55, 32'h0, "unmapped_wr");
    rd(STAT, 32'd4, "cnt_after_unmapped");
    rd(32'd0, 32'h3C, "ram0_intact");
    rd(BB + 32'd11, 32'h0, "unmapped_rd_btn_end");

    // Button 2: leave its sticky set with level low before reset
    buttons_i[2] = 1'b1;
    idle(4);
    buttons_i[2] = 1'b0;
    idle(2);

    // Write burst interrupted by asynchronous reset
    wr(32'd12, 32'h44, 32'h44, "burst_wr12");
    wr(32'd10, 32'h01, 32'h01, "burst_wr10");
    wr(32'd11, 32'h02, 32'h02, "burst_wr11");
    push_exp(32'h0, 1'b0, "async_reset");
    RST     = 1'b0;
    addr_i  = 32'd12;
    we_i    = 1'b1;
    wdata_i = 32'h77;
    repeat (2) @(negedge CLK);
    exp_err = 1'b0;
    RST = 1'b1;

    rd(32'd12, 32'h44, "no_write_under_reset");
    rd(32'd10, 32'h01, "ram_survives_reset");
    rd(STAT, 32'd0, "cnt_after_reset");
    wr(32'd13, 32'h99, 32'h99, "post_reset_wr13");
    rd(STAT, 32'd1, "cnt_restart");
    rd(BB + 32'd2, 32'h0, "btn2_sticky_reset");

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
